// File: rtl/psum_wb_pkg.sv
// Shared definitions for the psum writeback path: FSM encodings, SRAM word
// geometry and active-low strobe levels.
// Pure declarations; no logic, no latency, no flow control.
package psum_wb_pkg;

    // FSM encodings (kept as plain 2-bit constants for legacy tools)
    localparam logic [1:0] WB_IDLE  = 2'd0;
    localparam logic [1:0] WB_DRAIN = 2'd1;
    localparam logic [1:0] WB_DONE  = 2'd2;

    // Default OFIFO row geometry; one row fills one SRAM word
    localparam int WB_COL       = 8;
    localparam int WB_PSUM_BW   = 16;
    localparam int SRAM_WORD_BW = WB_COL * WB_PSUM_BW;

    // SRAM chip/write enables are active-low
    localparam logic SRAM_EN  = 1'b0;
    localparam logic SRAM_DIS = 1'b1;

    // The engine is busy in every state except IDLE
    function automatic logic wb_is_busy(input logic [1:0] st);
        return st != WB_IDLE;
    endfunction

endpackage

// File: rtl/psum_writeback_addr_gen.sv
// Address/count keeper for the writeback engine: latched base and length,
// pop and write counters, modulo address adder. Counters update one cycle
// after their increment request; no backpressure of its own.
module wb_addr_gen
    import psum_wb_pkg::*;
#(
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [addr_bw-1:0] base_in,
    input  logic [addr_bw:0]   num_in,
    input  logic               rd_inc,
    input  logic               wr_inc,
    output logic [addr_bw-1:0] wr_addr,
    output logic               rd_last,
    output logic               wr_last
);

    logic [addr_bw-1:0] base_q;
    logic [addr_bw:0]   num_q;
    logic [addr_bw:0]   rd_cnt;
    logic [addr_bw:0]   wr_cnt;

    // Latch the transfer descriptor on an accepted start, otherwise count pops and writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            num_q  <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (load) begin
            base_q <= base_in;
            num_q  <= num_in;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_inc) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (wr_inc) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Address wraps silently: the sum is truncated to the SRAM address width
    assign wr_addr = base_q + wr_cnt[addr_bw-1:0];
    assign rd_last = (rd_cnt == num_q);
    assign wr_last = (wr_cnt == num_q);

endmodule

// File: rtl/psum_writeback.sv
// Drains num_words OFIFO rows into consecutive psum SRAM addresses from base_addr.
// Latency: SRAM strobe 2 cycles after each pop, done 1 cycle after the last strobe.
// Backpressure: pops stall while ofifo_valid=0 or hold=1; in-flight rows still write.
module psum_writeback
    import psum_wb_pkg::*;
#(
    parameter int col     = WB_COL,
    parameter int psum_bw = WB_PSUM_BW,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic [addr_bw:0]         num_words,
    input  logic                     hold,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_bw-1:0]       sram_a,
    output logic [col*psum_bw-1:0]   sram_d,
    output logic                     busy,
    output logic                     done
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               rd_q;
    logic               start_acc;
    logic [addr_bw-1:0] wr_addr;
    logic               rd_last;
    logic               wr_last;

    assign start_acc = (state == WB_IDLE) && start;

    // Pop only while draining, data is available, the controller allows it and rows remain
    assign ofifo_rd = (state == WB_DRAIN) && ofifo_valid && !hold && !rd_last;

    wb_addr_gen #(
        .addr_bw (addr_bw)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (start_acc),
        .base_in (base_addr),
        .num_in  (num_words),
        .rd_inc  (ofifo_rd),
        .wr_inc  (rd_q),
        .wr_addr (wr_addr),
        .rd_last (rd_last),
        .wr_last (wr_last)
    );

    // Next-state logic; DRAIN exits on the cycle the final strobe is on the SRAM pins
    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: begin
                if (start) begin
                    state_nxt = (num_words == '0) ? WB_DONE : WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                if ((sram_cen == SRAM_EN) && wr_last) begin
                    state_nxt = WB_DONE;
                end
            end
            WB_DONE: begin
                state_nxt = WB_IDLE;
            end
            default: begin
                state_nxt = WB_IDLE;
            end
        endcase
    end

    // State register and the one-cycle pop-to-data delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WB_IDLE;
            rd_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q  <= ofifo_rd;
        end
    end

    // Registered SRAM interface: one single-cycle strobe per popped row, address/data hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_cen <= SRAM_DIS;
            sram_wen <= SRAM_DIS;
            sram_a   <= '0;
            sram_d   <= '0;
        end else if (rd_q) begin
            sram_cen <= SRAM_EN;
            sram_wen <= SRAM_EN;
            sram_a   <= wr_addr;
            sram_d   <= ofifo_out;
        end else begin
            sram_cen <= SRAM_DIS;
            sram_wen <= SRAM_DIS;
        end
    end

    assign busy = wb_is_busy(state);
    assign done = (state == WB_DONE);

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized scoreboard bench for psum_writeback with a queue-based OFIFO model.
module tb_psum_writeback;
    import psum_wb_pkg::*;

    localparam int AW = 11;
    localparam int DW = SRAM_WORD_BW;
    localparam int NADDR = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          hold = 1'b0;
    logic          ofifo_valid;
    logic [DW-1:0] ofifo_out = '0;
    logic          ofifo_rd;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic          busy;
    logic          done;

    psum_writeback dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .hold        (hold),
        .ofifo_valid (ofifo_valid),
        .ofifo_out   (ofifo_out),
        .ofifo_rd    (ofifo_rd),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_a      (sram_a),
        .sram_d      (sram_d),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // OFIFO model: rows stored in an array, data presented the cycle after a pop
    logic [DW-1:0] rows [0:4095];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic valid_en = 1'b0;
    assign ofifo_valid = valid_en && (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (ofifo_rd) begin
            ofifo_out <= rows[rd_ptr % 4096];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Scoreboard state
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t e;
    int  rd_log[$];
    int  st_log[$];
    int  done_log[$];
    int  busy_log[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  start_cyc = 0;
    bit  rand_mode = 1'b0;

    function automatic void chk(input bit ok, input string name,
                                input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: legality of pops, scoreboard compare on each SRAM strobe, done bookkeeping
    always @(negedge clk) begin
        if (ofifo_rd) begin
            rd_log.push_back(cyc);
            chk(ofifo_valid && !hold, "rd_legal", DW'({ofifo_valid, hold}), DW'(2'b10));
        end
        if (sram_cen == 1'b0 || sram_wen == 1'b0) begin
            st_log.push_back(cyc);
            chk(sram_cen == sram_wen, "cen_wen_pair", DW'({sram_cen, sram_wen}), DW'(2'b00));
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_strobe", DW'(sram_a), '0);
            end else begin
                e = exp_q.pop_front();
                chk(sram_a == e.a, "sram_a", DW'(sram_a), DW'(e.a));
                chk(sram_d == e.d, "sram_d", sram_d, e.d);
            end
        end
        if (busy) busy_log.push_back(cyc);
        if (done) begin
            done_log.push_back(cyc);
            chk(exp_q.size() == 0, "done_after_last_write", DW'(exp_q.size()), '0);
            chk(busy, "busy_at_done", DW'(busy), DW'(1));
        end
    end

    // Random valid/hold traffic when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                valid_en = ($urandom_range(0, 3) != 0);
                hold     = ($urandom_range(0, 4) == 0);
            end
        end
    end

    // Reference model: rows queued in the OFIFO, expected writes at (base+i) mod 2^AW
    task automatic push_drain(input int base, input int num);
        logic [DW-1:0] row;
        for (int i = 0; i < num; i++) begin
            row = {$urandom(), $urandom(), $urandom(), $urandom()};
            rows[wr_ptr % 4096] = row;
            wr_ptr++;
            exp_q.push_back('{a: AW'((base + i) % NADDR), d: row});
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        st_log.delete();
        done_log.delete();
        busy_log.delete();
    endtask

    // Called just after a rising edge; start is high for exactly this cycle
    task automatic issue_start(input int base, input int num);
        start     = 1'b1;
        base_addr = AW'(base);
        num_words = (AW+1)'(num);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_drain(input int base, input int num);
        push_drain(base, num);
        issue_start(base, num);
    endtask

    // Bounded wait for n done pulses; returns just after a rising edge
    task automatic wait_done(input int n, input int budget, input string name);
        int k = 0;
        while (done_log.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(done_log.size() >= n, {name, "_done_timeout"}, DW'(done_log.size()), DW'(n));
    endtask

    task automatic check_reset_outputs(input string name);
        chk(ofifo_rd == 1'b0, {name, "_ofifo_rd"}, DW'(ofifo_rd), '0);
        chk(sram_cen == 1'b1, {name, "_cen"}, DW'(sram_cen), DW'(1));
        chk(sram_wen == 1'b1, {name, "_wen"}, DW'(sram_wen), DW'(1));
        chk(sram_a == '0, {name, "_a"}, DW'(sram_a), '0);
        chk(sram_d == '0, {name, "_d"}, sram_d, '0);
        chk(busy == 1'b0, {name, "_busy"}, DW'(busy), '0);
        chk(done == 1'b0, {name, "_done"}, DW'(done), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic drain: base 0x010, 4 rows, valid always high
        valid_en = 1'b1;
        clear_logs();
        run_drain('h010, 4);
        wait_done(1, 50, "basic");
        chk(rd_log.size() == 4, "basic_pop_count", DW'(rd_log.size()), DW'(4));
        chk(st_log.size() == 4, "basic_strobe_count", DW'(st_log.size()), DW'(4));
        if (rd_log.size() == 4 && st_log.size() == 4 && done_log.size() >= 1 && busy_log.size() > 0) begin
            chk(rd_log[0] == start_cyc + 1, "basic_first_rd", DW'(rd_log[0] - start_cyc), DW'(1));
            chk(rd_log[3] - rd_log[0] == 3, "basic_rd_consecutive", DW'(rd_log[3] - rd_log[0]), DW'(3));
            chk(st_log[0] == rd_log[0] + 2, "basic_write_latency", DW'(st_log[0] - rd_log[0]), DW'(2));
            chk(done_log[0] == st_log[3] + 1, "basic_done_timing", DW'(done_log[0] - st_log[3]), DW'(1));
            chk(busy_log[0] == start_cyc + 1, "basic_busy_rise", DW'(busy_log[0] - start_cyc), DW'(1));
            chk(busy_log[busy_log.size()-1] == done_log[0], "basic_busy_fall",
                DW'(busy_log[busy_log.size()-1] - start_cyc), DW'(done_log[0] - start_cyc));
            chk(busy_log.size() == done_log[0] - start_cyc, "basic_busy_span",
                DW'(busy_log.size()), DW'(done_log[0] - start_cyc));
        end else begin
            chk(1'b0, "basic_logs_incomplete", DW'(rd_log.size()), DW'(4));
        end
        @(posedge clk);
        #1;
        chk(busy == 1'b0, "basic_idle_after", DW'(busy), '0);

        // Wrap-around: 0x7FE, 0x7FF, 0x000, 0x001
        clear_logs();
        run_drain('h7FE, 4);
        wait_done(1, 50, "wrap");
        chk(st_log.size() == 4, "wrap_strobe_count", DW'(st_log.size()), DW'(4));
        chk(sram_a == 11'h001, "wrap_last_addr_hold", DW'(sram_a), DW'(11'h001));

        // Stall: valid 1,0,0,1,1 with hold on the 4th DRAIN cycle
        @(posedge clk);
        #1;
        valid_en = 1'b0;
        clear_logs();
        push_drain('h155, 3);
        issue_start('h155, 3);
        for (int i = 0; i < 5; i++) begin
            valid_en = (i == 0 || i >= 3);
            hold     = (i == 3);
            @(posedge clk);
            #1;
        end
        valid_en = 1'b1;
        hold     = 1'b0;
        wait_done(1, 50, "stall");
        chk(rd_log.size() == 3, "stall_pop_count", DW'(rd_log.size()), DW'(3));
        chk(st_log.size() == 3, "stall_strobe_count", DW'(st_log.size()), DW'(3));
        chk(done_log.size() == 1, "stall_done_count", DW'(done_log.size()), DW'(1));
        if (rd_log.size() == 3) begin
            chk(rd_log[0] == start_cyc + 1 && rd_log[1] == start_cyc + 5 && rd_log[2] == start_cyc + 6,
                "stall_pop_cycles", DW'({rd_log[0] - start_cyc, rd_log[1] - start_cyc, rd_log[2] - start_cyc}),
                DW'({32'd1, 32'd5, 32'd6}));
        end

        // Zero-length drain: done only, no pop and no SRAM access
        @(posedge clk);
        #1;
        clear_logs();
        issue_start($urandom_range(0, NADDR - 1), 0);
        wait_done(1, 10, "zero");
        repeat (3) @(posedge clk);
        #1;
        chk(done_log.size() == 1, "zero_done_once", DW'(done_log.size()), DW'(1));
        if (done_log.size() >= 1) begin
            chk(done_log[0] - start_cyc >= 1 && done_log[0] - start_cyc <= 2, "zero_done_delay",
                DW'(done_log[0] - start_cyc), DW'(1));
        end
        chk(rd_log.size() == 0, "zero_no_pop", DW'(rd_log.size()), '0);
        chk(st_log.size() == 0, "zero_no_strobe", DW'(st_log.size()), '0);

        // Start while busy is ignored
        clear_logs();
        run_drain('h100, 5);
        issue_start('h3AA, 7);
        wait_done(1, 50, "busy_start");
        repeat (4) @(posedge clk);
        #1;
        chk(st_log.size() == 5, "busy_start_strobes", DW'(st_log.size()), DW'(5));
        chk(done_log.size() == 1, "busy_start_done", DW'(done_log.size()), DW'(1));
        chk(sram_a == 11'h104, "busy_start_last_addr", DW'(sram_a), DW'(11'h104));

        // Back-to-back: second start in the IDLE cycle right after done
        clear_logs();
        run_drain('h040, 2);
        wait_done(1, 50, "b2b_first");
        run_drain('h7FF, 1);
        wait_done(2, 50, "b2b_second");
        chk(st_log.size() == 3, "b2b_strobes", DW'(st_log.size()), DW'(3));
        chk(done_log.size() == 2, "b2b_done_pulses", DW'(done_log.size()), DW'(2));

        // Randomized drains with random valid/hold
        rand_mode = 1'b1;
        for (int t = 0; t < 8; t++) begin
            clear_logs();
            run_drain($urandom_range(0, NADDR - 1), $urandom_range(1, 9));
            wait_done(1, 400, "rand");
            chk(exp_q.size() == 0, "rand_all_written", DW'(exp_q.size()), '0);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        valid_en = 1'b1;
        hold     = 1'b0;

        // Reset mid-drain after three strobes, then a clean 2-row drain
        clear_logs();
        run_drain('h200, 8);
        for (int k = 0; k < 50 && st_log.size() < 3; k++) begin
            @(posedge clk);
        end
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        wr_ptr = rd_ptr;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk(st_log.size() == 3, "mid_reset_no_more_strobes", DW'(st_log.size()), DW'(3));
        clear_logs();
        run_drain('h020, 2);
        wait_done(1, 50, "post_reset");
        chk(st_log.size() == 2, "post_reset_strobes", DW'(st_log.size()), DW'(2));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
